// File: rtl/i2c_pkg.sv
// Shared FSM state type, status bit positions and bit-order helper
// for the I2C target block.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_e;

    localparam int FRAME_DONE     = 4;
    localparam int RX_FULL        = 3;
    localparam int RX_ALMOST_FULL = 2;
    localparam int TX_UNDERRUN    = 1;
    localparam int RX_OVERFLOW    = 0;
    localparam int STATUS_W       = 5;

    function automatic logic lead_bit(input logic [7:0] b,
                                      input logic       msb_first);
        return msb_first ? b[7] : b[0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy flags; head reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             almost_full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C  = DEPTH[AW:0];
    localparam logic [AW:0] AFULL_C = FULL_C - 1'b1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_push     = push & ~full;
    assign do_pop      = pop & ~empty;
    assign full        = (cnt_q == FULL_C);
    assign almost_full = (cnt_q == AFULL_C);
    assign empty       = (cnt_q == '0);
    assign rdata       = empty ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target (no clock stretching): 7-bit address match, write bytes into
// an RX FIFO, read bytes from a tx_data/tx_valid source.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h1A,
    parameter bit         MSB_LSB    = 1'b1,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [4:0] status
);

    logic   scl_m_q, scl_s_q, scl_p_q;
    logic   sda_m_q, sda_s_q, sda_p_q;
    logic   scl_rise, scl_fall, start, stop;
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] tx_q, tx_d;
    logic   oe_q, oe_d;
    logic   rw_q, rw_d;
    logic   match_q, match_d;
    logic   ovf_q, ovf_d;
    logic   unf_q, unf_d;
    logic   done_q, done_d;
    logic   txr_q, txr_d;
    logic   push, pop, load_rd;
    logic   full, afull, empty;
    logic [7:0] rx_bits;

    assign sda = oe_q ? 1'b0 : 1'bz;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            {scl_m_q, scl_s_q, scl_p_q} <= 3'b111;
            {sda_m_q, sda_s_q, sda_p_q} <= 3'b111;
        end else begin
            scl_m_q <= scl;
            scl_s_q <= scl_m_q;
            scl_p_q <= scl_s_q;
            sda_m_q <= sda;
            sda_s_q <= sda_m_q;
            sda_p_q <= sda_s_q;
        end
    end

    assign scl_rise = scl_s_q & ~scl_p_q;
    assign scl_fall = ~scl_s_q & scl_p_q;
    assign start    = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
    assign stop     = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;
    assign rx_bits  = MSB_LSB ? {sh_q[6:0], sda_s_q} : {sda_s_q, sh_q[7:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        oe_d    = oe_q;
        rw_d    = rw_q;
        match_d = match_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        done_d  = 1'b0;
        txr_d   = 1'b0;
        push    = 1'b0;
        load_rd = 1'b0;
        if (start) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            done_d  = match_q;
            match_d = 1'b0;
        end else begin
            unique case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        sh_d  = {sh_q[6:0], sda_s_q};
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (sh_q[7:1] == SLAVE_ADDR) begin
                            state_d = ADDR_ACK;
                            oe_d    = 1'b1;
                            rw_d    = sh_q[0];
                            match_d = 1'b1;
                            ovf_d   = 1'b0;
                            unf_d   = 1'b0;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        oe_d  = 1'b0;
                        cnt_d = '0;
                        if (rw_q) load_rd = 1'b1;
                        else      state_d = WR_BYTE;
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        sh_d  = rx_bits;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            // A full FIFO drops the byte and NACKs it.
                            if (full) begin
                                state_d = IGNORE;
                                ovf_d   = 1'b1;
                            end else begin
                                push = 1'b1;
                            end
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        state_d = WR_ACK;
                        oe_d    = 1'b1;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state_d = WR_BYTE;
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d = RD_ACK;
                            oe_d    = 1'b0;
                        end else begin
                            tx_d = MSB_LSB ? {tx_q[6:0], 1'b1}
                                           : {1'b1, tx_q[7:1]};
                            oe_d = ~lead_bit(tx_d, MSB_LSB);
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_s_q) state_d = IGNORE;
                    else if (scl_fall)       load_rd = 1'b1;
                end
                default: ;
            endcase
            if (load_rd) begin
                state_d = RD_BYTE;
                cnt_d   = '0;
                if (tx_valid) begin
                    tx_d  = tx_data;
                    txr_d = 1'b1;
                end else begin
                    tx_d  = 8'hFF;
                    unf_d = 1'b1;
                end
                oe_d = ~lead_bit(tx_d, MSB_LSB);
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            tx_q    <= '0;
            oe_q    <= 1'b0;
            rw_q    <= 1'b0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            done_q  <= 1'b0;
            txr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            oe_q    <= oe_d;
            rw_q    <= rw_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            done_q  <= done_d;
            txr_q   <= txr_d;
        end
    end

    assign rx_valid = ~empty;
    assign pop      = rx_valid & rx_ready;
    assign tx_ready = txr_q;

    always_comb begin
        status                 = '0;
        status[FRAME_DONE]     = done_q;
        status[RX_FULL]        = full;
        status[RX_ALMOST_FULL] = afull;
        status[TX_UNDERRUN]    = unf_q;
        status[RX_OVERFLOW]    = ovf_q;
    end

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_rx_fifo (
        .clk        (pclk),
        .rst_n      (presetn),
        .push       (push),
        .wdata      (rx_bits),
        .pop        (pop),
        .rdata      (rx_data),
        .full       (full),
        .almost_full(afull),
        .empty      (empty)
    );

endmodule
